dram_read_arbiter: RTL and testbench

Round-robin arbiter that shares the single 32-bit DRAM read port among the layer controllers (bias loader, weight loader, input-feature loader). Each requester keeps its existing DRAM port: it asserts Read with a stable Address and waits for DataReady. The arbiter serializes these requests onto the physical port, one outstanding read at a time. A watchdog flags DRAM reads that never complete.

---
 rtl/dram_read_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dram_read_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter serializing per-loader read requests onto the single DRAM read port,
// one outstanding read at a time, with a sticky watchdog for reads that never complete.
module dram_read_arbiter #(
  parameter  int REQ_NUM = 3,
  parameter  int TIMEOUT = 1024,
  localparam int GW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int WDW     = $clog2(TIMEOUT) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [REQ_NUM-1:0]      req_Read,
  input  logic [REQ_NUM-1:0][31:0] req_Address,
  output logic [31:0]             req_ReadData,
  output logic [REQ_NUM-1:0]      req_DataReady,
  output logic                    DRAM_Read,
  output logic [31:0]             DRAM_Address,
  input  logic [31:0]             DRAM_ReadData,
  input  logic                    DRAM_DataReady,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [GW-1:0]    grant_id_r, grant_id_s;
  logic [GW-1:0]    rr_ptr_r, rr_ptr_s;
  logic [31:0]      dram_address_r, dram_address_s;
  logic [WDW-1:0]   wd_cnt_r, wd_cnt_s;
  logic             timeout_err_r, timeout_err_s;

  // First requesting index at or after ptr, wrapping modulo REQ_NUM; searched from the
  // farthest offset down so the closest one wins.
  function automatic logic [GW-1:0] rr_pick(input logic [REQ_NUM-1:0] reqs,
                                            input logic [GW-1:0]      ptr);
    logic [GW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % REQ_NUM;
      if (reqs[idx]) begin
        pick = GW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Next-state and next-register computation
  always_comb begin
    state_s        = state_r;
    grant_id_s     = grant_id_r;
    rr_ptr_s       = rr_ptr_r;
    dram_address_s = dram_address_r;
    wd_cnt_s       = wd_cnt_r;
    timeout_err_s  = timeout_err_r;
    case (state_r)
      S_IDLE: begin
        if (|req_Read) begin
          grant_id_s     = rr_pick(req_Read, rr_ptr_r);
          dram_address_s = req_Address[grant_id_s];
          state_s        = S_GRANT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_GRANT: begin
        wd_cnt_s = '0;
        state_s  = S_WAIT;
      end
      S_WAIT: begin
        // Counter saturates so the sticky flag never depends on wrap-around.
        if (wd_cnt_r < WDW'(TIMEOUT)) begin
          wd_cnt_s = wd_cnt_r + WDW'(1);
        end else begin
          wd_cnt_s = wd_cnt_r;
        end
        if (wd_cnt_r >= WDW'(TIMEOUT - 1)) begin
          timeout_err_s = 1'b1;
        end else begin
          timeout_err_s = timeout_err_r;
        end
        if (DRAM_DataReady) begin
          state_s = S_RELEASE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RELEASE: begin
        if (int'(grant_id_r) == REQ_NUM - 1) begin
          rr_ptr_s = '0;
        end else begin
          rr_ptr_s = grant_id_r + GW'(1);
        end
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= S_IDLE;
      grant_id_r     <= '0;
      rr_ptr_r       <= '0;
      dram_address_r <= 32'd0;
      wd_cnt_r       <= '0;
      timeout_err_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      grant_id_r     <= grant_id_s;
      rr_ptr_r       <= rr_ptr_s;
      dram_address_r <= dram_address_s;
      wd_cnt_r       <= wd_cnt_s;
      timeout_err_r  <= timeout_err_s;
    end
  end

  // Port-side decode; the completion pulse is combinational so requesters see it with the data
  always_comb begin
    DRAM_Read     = 1'b0;
    busy          = 1'b0;
    req_DataReady = '0;
    case (state_r)
      S_IDLE: begin
        DRAM_Read = 1'b0;
        busy      = 1'b0;
      end
      S_GRANT: begin
        DRAM_Read = 1'b1;
        busy      = 1'b1;
      end
      S_WAIT: begin
        DRAM_Read = 1'b1;
        busy      = 1'b1;
        for (int i = 0; i < REQ_NUM; i++) begin
          if (DRAM_DataReady && (int'(grant_id_r) == i)) begin
            req_DataReady[i] = 1'b1;
          end else begin
            req_DataReady[i] = 1'b0;
          end
        end
      end
      S_RELEASE: begin
        DRAM_Read = 1'b0;
        busy      = 1'b1;
      end
      default: begin
        DRAM_Read = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  assign req_ReadData = DRAM_ReadData;
  assign DRAM_Address = dram_address_r;
  assign grant_id     = grant_id_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Randomized bench for dram_read_arbiter against a transaction-level round-robin model.
module tb_dram_read_arbiter;
  localparam int REQ_NUM = 3;
  localparam int TIMEOUT = 8;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [REQ_NUM-1:0]       req_Read;
  logic [REQ_NUM-1:0][31:0] req_Address;
  logic [31:0]              req_ReadData;
  logic [REQ_NUM-1:0]       req_DataReady;
  logic                     DRAM_Read;
  logic [31:0]              DRAM_Address;
  logic [31:0]              DRAM_ReadData;
  logic                     DRAM_DataReady;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int rr_m;
  bit err_m;
  int last_grant;

  always #5 clock = ~clock;

  dram_read_arbiter #(.REQ_NUM(REQ_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_Read(req_Read), .req_Address(req_Address),
    .req_ReadData(req_ReadData), .req_DataReady(req_DataReady),
    .DRAM_Read(DRAM_Read), .DRAM_Address(DRAM_Address),
    .DRAM_ReadData(DRAM_ReadData), .DRAM_DataReady(DRAM_DataReady),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  function automatic int pick(input logic [2:0] m, input int ptr);
    for (int off = 0; off < REQ_NUM; off++) begin
      if (m[(ptr + off) % REQ_NUM]) return (ptr + off) % REQ_NUM;
    end
    return -1;
  endfunction

  task automatic rand_addr;
    for (int i = 0; i < REQ_NUM; i++) req_Address[i] = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_Read = '0;
    DRAM_DataReady = 1'b0;
    tick;
    tick;
    check("rst_read", DRAM_Read, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_addr", DRAM_Address, 0);
    check("rst_err", timeout_err, 0);
    check("rst_pulse", req_DataReady, 0);
    reset = 1'b0;
    rr_m = 0;
    err_m = 0;
  endtask

  // One full transaction from IDLE back to IDLE, DRAM completion after lat extra WAIT cycles
  task automatic txn(input logic [2:0] mask, input int lat, input bit withdraw, input logic [31:0] data);
    int g;
    logic [31:0] a;
    req_Read = mask;
    g = pick(mask, rr_m);
    a = req_Address[g];
    #1;
    check("idle_read", DRAM_Read, 0);
    check("idle_busy", busy, 0);
    tick;
    last_grant = int'(grant_id);
    check("grant_read", DRAM_Read, 1);
    check("grant_busy", busy, 1);
    check("grant_gid", grant_id, g);
    check("grant_addr", DRAM_Address, a);
    if (withdraw) begin
      req_Read[g] = 1'b0;
      req_Address[g] = ~a;
    end
    for (int j = 1; j <= lat + 1; j++) begin
      tick;
      check("wait_read", DRAM_Read, 1);
      check("wait_addr", DRAM_Address, a);
      check("wait_err", timeout_err, (err_m || (j - 1 >= TIMEOUT)) ? 1 : 0);
      if (j == lat + 1) begin
        DRAM_ReadData = data;
        DRAM_DataReady = 1'b1;
        #1;
        check("done_pulse", req_DataReady, 32'd1 << g);
        check("done_data", req_ReadData, data);
      end else begin
        DRAM_ReadData = $urandom;
        #1;
        check("wait_pulse", req_DataReady, 0);
      end
    end
    tick;
    DRAM_DataReady = 1'b0;
    err_m = err_m || (lat + 1 >= TIMEOUT);
    #1;
    check("rel_read", DRAM_Read, 0);
    check("rel_busy", busy, 1);
    check("rel_pulse", req_DataReady, 0);
    check("rel_err", timeout_err, err_m ? 1 : 0);
    tick;
    check("end_busy", busy, 0);
    check("end_read", DRAM_Read, 0);
    rr_m = (g + 1) % REQ_NUM;
  endtask

  initial begin
    int exp_seq[4];
    reset = 1'b1;
    req_Read = '0;
    req_Address = '0;
    DRAM_ReadData = 32'd0;
    DRAM_DataReady = 1'b0;
    do_reset;
    DRAM_ReadData = 32'hA5A5_5A5A;
    #1;
    check("passthru", req_ReadData, 32'hA5A5_5A5A);

    // idle with a stray completion: nothing happens
    DRAM_DataReady = 1'b1;
    #1;
    check("stray_idle_pulse", req_DataReady, 0);
    tick;
    DRAM_DataReady = 1'b0;
    check("stray_idle_busy", busy, 0);

    // single requester
    rand_addr;
    req_Address[0] = 32'h100;
    txn(3'b001, 3, 1'b0, 32'hDEAD_BEEF);
    check("single_gid", last_grant, 0);

    // all three continuously
    do_reset;
    rand_addr;
    exp_seq = '{0, 1, 2, 0};
    for (int k = 0; k < 4; k++) begin
      txn(3'b111, $urandom_range(0, 3), 1'b0, $urandom);
      check("seq_all", last_grant, exp_seq[k]);
    end

    // fairness with requester 1 idle
    do_reset;
    rand_addr;
    exp_seq = '{0, 2, 0, 2};
    for (int k = 0; k < 4; k++) begin
      txn(3'b101, $urandom_range(0, 3), 1'b0, $urandom);
      check("seq_fair", last_grant, exp_seq[k]);
    end

    // withdrawal and address change while in flight
    do_reset;
    rand_addr;
    txn(3'b010, 4, 1'b1, 32'h1234_5678);
    check("wd_gid", last_grant, 1);
    txn(3'b001, 1, 1'b0, 32'h0BAD_F00D);
    check("wd_next_gid", last_grant, 0);

    // randomized traffic
    do_reset;
    for (int k = 0; k < 25; k++) begin
      rand_addr;
      txn(3'($urandom_range(1, 7)), $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom);
    end

    // watchdog: completion withheld past TIMEOUT, then a normal read
    do_reset;
    rand_addr;
    txn(3'b001, 12, 1'b0, $urandom);
    txn(3'b010, 1, 1'b0, $urandom);
    check("wdog_sticky", timeout_err, 1);

    // reset in WAIT
    rand_addr;
    req_Read = 3'b100;
    tick;
    tick;
    tick;
    check("mid_busy_pre", busy, 1);
    reset = 1'b1;
    tick;
    check("mid_read", DRAM_Read, 0);
    check("mid_busy", busy, 0);
    check("mid_gid", grant_id, 0);
    check("mid_err", timeout_err, 0);
    reset = 1'b0;
    req_Read = '0;
    rr_m = 0;
    err_m = 0;
    DRAM_DataReady = 1'b1;
    #1;
    check("mid_stray_pulse", req_DataReady, 0);
    tick;
    DRAM_DataReady = 1'b0;
    check("mid_stray_busy", busy, 0);
    txn(3'b111, 2, 1'b0, $urandom);
    check("mid_rr_gid", last_grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
